spi_slave_core: RTL and testbench
=================================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers on i_sck, i_ss_n and i_mosi.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high: i_sys_clk  in  1  system clock, all logic on its rising edge.
REQ-004 i_sys_rst  in  1  synchronous active-high reset.
REQ-005 i_spe  in  1  slave enable; low forces IDLE.
REQ-006 i_cpol, i_cpha, i_lsbfe  in  1 each  clock polarity, clock phase, LSB-first select.
REQ-007 i_sck, i_ss_n, i_mosi  in  1 each  asynchronous SPI pins from the master.
REQ-008 o_miso  out  1  serial data to the master.
REQ-009 o_miso_oe  out  1  MISO pad enable, used for tristate at top level.
REQ-010 i_tx_data  in  DATA_WIDTH  next transmit word.
REQ-011 i_tx_valid  in  1  transmit word offered.
REQ-012 o_tx_ready  out  1  transmit holding register empty.
REQ-013 o_rx_data  out  DATA_WIDTH  last received word.
REQ-014 o_rx_valid  out  1  o_rx_data unread.
REQ-015 i_rx_rd  in  1  read acknowledge.
REQ-016 o_overrun  out  1  sticky overrun flag.
REQ-017 i_ovr_clr  in  1  clears o_overrun.
REQ-018 o_busy  out  1  frame in progress.

Function
REQ-019 The three pin inputs SHALL pass through SYNC_STAGES flip-flops; SCK edges SHALL be detected against one further registered copy, so a pin edge is acted on SYNC_STAGES+1 cycles later. The i_sys_clk frequency SHALL be at least 8x the SCK frequency.
REQ-020 The state machine SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-021 IDLE -> LOAD on a synchronized i_ss_n falling edge while i_spe=1.
REQ-022 LOAD SHALL last one cycle:
 - latch i_cpol, i_cpha and i_lsbfe for the frame;
 - copy the holding register into the shift register, or all zeros if the holding register is empty;
 - mark the holding register empty;
 - clear the bit counter;
 - go to SHIFT.
REQ-023 The leading edge SHALL be the SCK transition away from the latched CPOL; the trailing edge SHALL be the opposite transition.
REQ-024 With CPHA=0, o_miso SHALL present the first bit from LOAD, sample MOSI on leading edges, and shift out the next bit on trailing edges.
REQ-025 With CPHA=1, the block SHALL shift out a bit on each leading edge and sample MOSI on trailing edges.
REQ-026 The first bit out SHALL be shift[0] when LSB-first is set, otherwise shift[DATA_WIDTH-1]. Sampled bits SHALL enter from the opposite end, giving a full-duplex rotate.
REQ-027 Each sample edge SHALL increment a counter of width clog2(DATA_WIDTH)+1. When the counter reaches DATA_WIDTH, the frame completes and the state goes to DONE on the next cycle.
REQ-028 On frame completion with o_rx_valid=0, the block SHALL load o_rx_data and set o_rx_valid in the same cycle.
REQ-029 On frame completion with o_rx_valid=1, o_rx_data SHALL be kept unchanged and o_overrun SHALL be set.
REQ-030 DONE -> IDLE on synchronized i_ss_n high. SCK edges in DONE SHALL be ignored, so one frame is exchanged per SS assertion.
REQ-031 Abort: synchronized i_ss_n rising, or i_spe low, in LOAD or SHIFT SHALL send the state to IDLE, discard the partial word, and leave o_rx_valid/o_rx_data unchanged.
REQ-032 o_miso_oe SHALL be 1 only in LOAD, SHIFT or DONE while synchronized i_ss_n=0. o_miso SHALL be 0 whenever o_miso_oe=0.
REQ-033 o_busy SHALL be 1 in LOAD and SHIFT.
REQ-034 Transmit handshake: when i_tx_valid and o_tx_ready are both 1, the holding register SHALL load i_tx_data and o_tx_ready SHALL go to 0 next cycle.
REQ-035 o_tx_ready SHALL return to 1 the cycle after LOAD consumes the holding register.
REQ-036 When a handshake and LOAD occur in the same cycle, LOAD SHALL take the old holding content; the new word SHALL be held and o_tx_ready SHALL go to 0.
REQ-037 o_rx_valid SHALL clear on i_rx_rd. If i_rx_rd coincides with frame completion, the new word SHALL be stored, o_rx_valid SHALL remain 1, and no overrun SHALL be set.
REQ-038 o_overrun SHALL clear on i_ovr_clr. Set takes priority over a simultaneous clear.
REQ-039 Changes to i_cpol, i_cpha or i_lsbfe outside LOAD SHALL have no effect on the current frame.

Reset
REQ-040 When i_sys_rst=1 at a clock edge, the block SHALL enter IDLE and clear all of the following to zero:
 - shift and holding registers;
 - bit counter;
 - synchronizers;
 - o_rx_data.
REQ-041 After reset: o_tx_ready=1, and o_rx_valid, o_overrun, o_busy, o_miso and o_miso_oe are all 0. Reset SHALL take effect mid-frame with no completion.

Verification
REQ-042 The bench SHALL cover these directed scenarios:
 - Mode 0, MSB-first: tx 0xA5 loaded, master sends 0x3C -> master receives 0xA5, o_rx_data=0x3C, o_rx_valid=1.
 - Mode 3, LSB-first: tx 0x81, master sends 0x7E -> master receives 0x81 LSB-first, o_rx_data=0x7E.
 - Second frame completes with o_rx_valid=1 -> o_overrun=1, o_rx_data keeps the first word; i_ovr_clr -> o_overrun=0.
 - Empty holding register -> master receives 0x00. i_tx_valid during a frame is accepted; o_tx_ready stays 0 until the next LOAD.
 - SS released after 4 SCK edges -> IDLE, o_rx_valid stays 0; the next full frame is correct.
 - i_sys_rst=1 mid-SHIFT -> next cycle all outputs at reset values, o_tx_ready=1.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave core: synchronized pin sampling, four-state frame control, full-duplex
// shift register with one-word transmit holding register and receive buffer.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_spe,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsbfe,
  input  logic                  i_sck,
  input  logic                  i_ss_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_rd,
  output logic                  o_overrun,
  input  logic                  i_ovr_clr,
  output logic                  o_busy
);
  localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                    sck_prev_q, ss_prev_q;
  logic                    sck_s, ss_s, mosi_s;
  logic                    sck_rise, sck_fall, ss_rise, ss_fall;
  logic                    lead_e, trail_e, sample_e, shift_e;
  logic                    abort, frame_done, handshake;
  logic                    busy_s, miso_oe_s;
  logic [DATA_WIDTH-1:0]   load_word;

  logic                    cpol_q, cpha_q, lsbfe_q, cpol_d, cpha_d, lsbfe_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hold_empty_q, hold_empty_d;
  logic                    rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic                    miso_bit_q, miso_bit_d;

  // Low SYNC_STAGES bits of {q, pin} shift the pin in at bit 0.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= SYNC_STAGES'({sck_sync_q, i_sck});
      ss_sync_q   <= SYNC_STAGES'({ss_sync_q, i_ss_n});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, i_mosi});
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign lead_e   = cpol_q ? sck_fall : sck_rise;
  assign trail_e  = cpol_q ? sck_rise : sck_fall;
  assign sample_e = cpha_q ? trail_e : lead_e;
  assign shift_e  = cpha_q ? lead_e : trail_e;

  assign abort      = ss_rise | ~i_spe;
  assign frame_done = (state_q == ST_SHIFT) && (cnt_q == CNT_FULL);
  assign handshake  = i_tx_valid & hold_empty_q;
  assign load_word  = hold_empty_q ? '0 : hold_q;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A completed word wins over a coincident abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (i_spe && ss_fall) ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (frame_done) begin
          state_d = ST_DONE;
        end else if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE:  state_d = ss_s ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_s    = 1'b0;
    miso_oe_s = 1'b0;
    case (state_q)
      ST_LOAD, ST_SHIFT: begin
        busy_s    = 1'b1;
        miso_oe_s = ~ss_s;
      end
      ST_DONE: miso_oe_s = ~ss_s;
      default: begin
        busy_s    = 1'b0;
        miso_oe_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    lsbfe_d      = lsbfe_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    miso_bit_d   = miso_bit_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;

    if (state_q == ST_LOAD) begin
      cpol_d       = i_cpol;
      cpha_d       = i_cpha;
      lsbfe_d      = i_lsbfe;
      shift_d      = load_word;
      miso_bit_d   = i_lsbfe ? load_word[0] : load_word[DATA_WIDTH-1];
      cnt_d        = '0;
      hold_empty_d = 1'b1;
    end else if (state_q == ST_SHIFT && !frame_done) begin
      if (sample_e) begin
        shift_d = lsbfe_q ? {mosi_s, shift_q[DATA_WIDTH-1:1]}
                          : {shift_q[DATA_WIDTH-2:0], mosi_s};
        cnt_d   = cnt_q + CNT_W'(1);
      end else if (shift_e) begin
        miso_bit_d = lsbfe_q ? shift_q[0] : shift_q[DATA_WIDTH-1];
      end else begin
        miso_bit_d = miso_bit_q;
      end
    end else begin
      shift_d = shift_q;
    end

    // A word offered during LOAD is kept for the next frame.
    if (handshake) begin
      hold_d       = i_tx_data;
      hold_empty_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end

    if (frame_done && (!rx_valid_q || i_rx_rd)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (i_rx_rd) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (frame_done && rx_valid_q && !i_rx_rd) begin
      overrun_d = 1'b1;
    end else if (i_ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsbfe_q      <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      miso_bit_q   <= 1'b0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsbfe_q      <= lsbfe_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      miso_bit_q   <= miso_bit_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_miso     = miso_oe_s & miso_bit_q;
  assign o_miso_oe  = miso_oe_s;
  assign o_busy     = busy_s;
  assign o_tx_ready = hold_empty_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: the bench plays the SPI master and checks
// both directions of each frame plus the buffer/handshake flags.
module tb_spi_slave_core;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst, spe, cpol, cpha, lsbfe, sck, ss_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, rx_rd, overrun, ovr_clr, busy;
  logic [7:0] tx_data, rx_data, mrx;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_spe(spe),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsbfe(lsbfe),
    .i_sck(sck), .i_ss_n(ss_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_rd(rx_rd),
    .o_overrun(overrun), .i_ovr_clr(ovr_clr), .o_busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_rd();
    rx_rd = 1'b1;
    wait_cyc(1);
    rx_rd = 1'b0;
  endtask

  // Master side of one frame; DUT config pins are scrambled once the frame is latched.
  task automatic spi_xfer(input logic m_cpol, input logic m_cpha, input logic m_lsb,
                          input logic [7:0] mtx, input int nbits, input logic raise_ss,
                          input logic push_mid, input logic [7:0] mid_word,
                          output logic [7:0] rxw);
    logic [7:0] r;
    int         idx;
    r     = 8'h00;
    cpol  = m_cpol;
    cpha  = m_cpha;
    lsbfe = m_lsb;
    sck   = m_cpol;
    mosi  = 1'b0;
    wait_cyc(4);
    ss_n = 1'b0;
    wait_cyc(6);
    check_eq("xfer_busy", busy, 1'b1);
    check_eq("xfer_oe", miso_oe, 1'b1);
    cpol  = ~m_cpol;
    cpha  = ~m_cpha;
    lsbfe = ~m_lsb;
    if (push_mid) push_tx(mid_word);
    for (int i = 0; i < nbits; i++) begin
      idx = m_lsb ? i : 7 - i;
      if (!m_cpha) begin
        mosi = mtx[idx];
        wait_cyc(HALF);
        sck    = ~m_cpol;
        r[idx] = miso;
        wait_cyc(HALF);
        sck = m_cpol;
      end else begin
        wait_cyc(HALF);
        sck  = ~m_cpol;
        mosi = mtx[idx];
        wait_cyc(HALF);
        sck    = m_cpol;
        r[idx] = miso;
      end
    end
    wait_cyc(HALF);
    if (raise_ss) begin
      ss_n = 1'b1;
      wait_cyc(6);
      check_eq("end_oe", miso_oe, 1'b0);
      check_eq("end_miso", miso, 1'b0);
      check_eq("end_busy", busy, 1'b0);
    end
    rxw = r;
  endtask

  initial begin
    rst = 1'b1; spe = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_rd = 1'b0; ovr_clr = 1'b0;
    wait_cyc(3);
    check_eq("rst_tx_ready", tx_ready, 1'b1);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_oe", miso_oe, 1'b0);
    check_eq("rst_miso", miso, 1'b0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wait_cyc(4);

    // Mode 0, MSB first
    push_tx(8'hA5);
    check_eq("m0_tx_ready_lo", tx_ready, 1'b0);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 8, 1'b1, 1'b0, 8'h00, mrx);
    check_eq("m0_master_rx", mrx, 8'hA5);
    check_eq("m0_rx_data", rx_data, 8'h3C);
    check_eq("m0_rx_valid", rx_valid, 1'b1);
    check_eq("m0_tx_ready_hi", tx_ready, 1'b1);
    check_eq("m0_overrun", overrun, 1'b0);
    pulse_rd();
    check_eq("m0_rd_clears", rx_valid, 1'b0);

    // Mode 3, LSB first; result left unread
    push_tx(8'h81);
    spi_xfer(1'b1, 1'b1, 1'b1, 8'h7E, 8, 1'b1, 1'b0, 8'h00, mrx);
    check_eq("m3_master_rx", mrx, 8'h81);
    check_eq("m3_rx_data", rx_data, 8'h7E);
    check_eq("m3_rx_valid", rx_valid, 1'b1);

    // Overrun with empty holding register and a word accepted mid-frame
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h55, 8, 1'b1, 1'b1, 8'h42, mrx);
    check_eq("ovr_master_rx", mrx, 8'h00);
    check_eq("ovr_set", overrun, 1'b1);
    check_eq("ovr_rx_kept", rx_data, 8'h7E);
    check_eq("ovr_rx_valid", rx_valid, 1'b1);
    check_eq("mid_tx_ready", tx_ready, 1'b0);
    ovr_clr = 1'b1;
    wait_cyc(1);
    ovr_clr = 1'b0;
    check_eq("ovr_clr", overrun, 1'b0);
    pulse_rd();
    check_eq("ovr_rd_clears", rx_valid, 1'b0);
    wait_cyc(10);
    check_eq("idle_tx_ready", tx_ready, 1'b0);

    // Abort after 4 SCK edges, then a full mode 1 frame
    spi_xfer(1'b0, 1'b0, 1'b0, 8'hFF, 2, 1'b1, 1'b0, 8'h00, mrx);
    check_eq("abort_rx_valid", rx_valid, 1'b0);
    check_eq("abort_rx_data", rx_data, 8'h7E);
    check_eq("abort_tx_ready", tx_ready, 1'b1);
    push_tx(8'hC3);
    spi_xfer(1'b0, 1'b1, 1'b0, 8'h96, 8, 1'b1, 1'b0, 8'h00, mrx);
    check_eq("m1_master_rx", mrx, 8'hC3);
    check_eq("m1_rx_data", rx_data, 8'h96);
    check_eq("m1_rx_valid", rx_valid, 1'b1);

    // Reset in the middle of SHIFT
    pulse_rd();
    push_tx(8'h11);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'hAA, 2, 1'b0, 1'b0, 8'h00, mrx);
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    wait_cyc(1);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_tx_ready", tx_ready, 1'b1);
    check_eq("mrst_rx_valid", rx_valid, 1'b0);
    check_eq("mrst_overrun", overrun, 1'b0);
    check_eq("mrst_oe", miso_oe, 1'b0);
    check_eq("mrst_miso", miso, 1'b0);
    check_eq("mrst_rx_data", rx_data, 8'h00);
    rst  = 1'b0;
    ss_n = 1'b1;
    wait_cyc(8);
    check_eq("post_rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
